// File: rtl/system_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : system_memory_arbiter
// Purpose  : Round-robin sharing of one 32-bit system-memory port between two
//            Avalon-MM masters, with per-master pipelined read returns.
// Revision : 1.0 - initial release
// ============================================================================
module system_memory_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,

  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [3:0]            m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [31:0]           m0_writedata,
  output logic                  m0_waitrequest,
  output logic [31:0]           m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [3:0]            m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [31:0]           m1_writedata,
  output logic                  m1_waitrequest,
  output logic [31:0]           m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [31:0]           mem_writedata,
  input  logic [31:0]           mem_readdata
);

  logic                    w_m0_req;
  logic                    w_m1_req;
  logic                    w_grant0;
  logic                    w_grant1;
  logic                    w_rd_accept;
  logic                    w_rd_owner;
  logic                    r_last_grant;
  logic [READ_LATENCY-1:0] r_tag_valid;
  logic [READ_LATENCY-1:0] r_tag_owner;

  assign w_m0_req = m0_read | m0_write;
  assign w_m1_req = m1_read | m1_write;

  // Grant decided in the request cycle; reset is part of the grant term so no
  // transfer can slip through while the block is being reset.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!reset && !hold) begin
      if (w_m0_req && w_m1_req) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = w_m0_req;
        w_grant1 = w_m1_req;
      end
    end
  end

  assign m0_waitrequest = w_m0_req & ~w_grant0;
  assign m1_waitrequest = w_m1_req & ~w_grant1;

  // A simultaneous read+write is treated as a write, so reads require ~write.
  assign w_rd_accept = (w_grant0 & m0_read & ~m0_write)
                     | (w_grant1 & m1_read & ~m1_write);
  assign w_rd_owner  = w_grant1;

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (w_grant0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end else if (w_grant1) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_grant0 || w_grant1) begin
      r_last_grant <= w_grant1;
    end
  end

  // Tag pipeline mirrors the memory read latency; the final stage steers the
  // returning data to its owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_valid <= '0;
      r_tag_owner <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_owner[i] <= r_tag_owner[i-1];
      end
      r_tag_valid[0] <= w_rd_accept;
      r_tag_owner[0] <= w_rd_owner;
    end
  end

  assign m0_readdatavalid = r_tag_valid[READ_LATENCY-1] & ~r_tag_owner[READ_LATENCY-1];
  assign m1_readdatavalid = r_tag_valid[READ_LATENCY-1] &  r_tag_owner[READ_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  a_m0_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  a_m1_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule
`default_nettype wire

// File: doc/system_memory_arbiter.md
Name: system_memory_arbiter

Overview:
Shares one 32-bit port of the on-chip dual-port system memory between two Avalon-MM masters (m0, m1), e.g. a CPU data master and a DMA engine, while the other memory port stays dedicated.
Arbitration is round-robin, one transfer per cycle, with pipelined reads.
The arbiter tracks outstanding reads so that each master gets its own readdatavalid at the memory's fixed read latency.
A hold input stalls all new transfers, for reset-request and freeze handling.

Parameters:
ADDR_WIDTH, 14, word address width (64 KiB / 4 bytes).
READ_LATENCY, 1, cycles from accepted read to valid mem_readdata; legal values 1 or 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hold  in  1  when 1, no new transfer is granted
m0_address  in  ADDR_WIDTH  master 0 word address
m0_byteenable  in  4  master 0 byte enables
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  32  master 0 write data
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  32  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_*  (same set as m0_*)  master 1
mem_address  out  ADDR_WIDTH  to memory port
mem_byteenable  out  4  to memory port
mem_chipselect  out  1  to memory port
mem_write  out  1  to memory port
mem_writedata  out  32  to memory port
mem_readdata  in  32  from memory port

Behaviour:
- Request: mX_req = mX_read | mX_write. mX_read and mX_write both 1 is illegal: treat as write and flag with a simulation assertion.
- State: last_grant (1 bit, reset 1, so m0 wins the first contest); rd_tag shift register, READ_LATENCY stages, each {valid, owner}, reset all 0.
- Grant is combinational, in the cycle the request is presented:
  - if reset or hold: no grant;
  - else if only one master requests: grant it;
  - else if both request: grant ~last_grant.
- On a grant, last_grant <= granted master at the clock edge. With no grant, last_grant holds.
- Waitrequest: mX_waitrequest = mX_req & ~grant_X. Waitrequest is 0 when the master is idle. Both waitrequests are 1 for requesting masters during reset or hold.
- Memory drive:
  - mem_chipselect = any grant;
  - mem_write = granted master's write;
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master;
  - with no grant, all mem_* outputs are 0.
  - Reset values: all mem_* = 0.
- Reads:
  - An accepted read pushes {1, owner} into rd_tag stage 0; the tag shifts one stage per cycle.
  - At the final stage, mX_readdatavalid = valid & (owner == X).
  - mX_readdata = mem_readdata for both masters; data is qualified only by readdatavalid.
  - Read latency seen by a master = READ_LATENCY cycles after the accepted cycle. Back-to-back reads return in order, one per cycle.
- Writes complete in the accepted cycle and push no tag.
- Simultaneous events:
  - A read accepted for one master in the same cycle as a return to the other is legal.
  - Alternating grants under continuous dual demand give exact 50/50 interleave: m0, m1, m0, m1…
- hold mid-stream: new grants stop immediately; reads already in flight still return.
- reset mid-operation: all in-flight tags are cleared asynchronously, no readdatavalid is produced for them, and last_grant returns to 1.
- Address wrap: none. Addresses pass through unmodified.

Test Plan:
- Reset asserted with both masters requesting → waitrequest 1/1, mem_chipselect 0, readdatavalid 0. Release → m0 granted first cycle.
- m0 reads addr 0x0010 (memory holds 0xDEADBEEF), m1 idle → m0_waitrequest 0, m0_readdatavalid 1 exactly 1 cycle later with data 0xDEADBEEF. m1_readdatavalid stays 0.
- Both masters issue 4 continuous reads each (m0 addrs 0–3, m1 addrs 8–11) → mem_address sequence 0, 8, 1, 9, 2, 10, 3, 11. Each master receives its 4 valids in order, and no data is delivered to the wrong master.
- m0 write 0x12345678 byteenable 0x3 to addr 5 while m1 reads addr 5 in the next cycle → m1 gets low half 0x5678 merged with the prior upper bytes.
- hold raised while m1 has a read in flight → m1 readdatavalid still fires. Afterwards no mem_chipselect and both waitrequests stay 1 until hold drops.
- READ_LATENCY = 2; reset asserted one cycle after a read is accepted → no readdatavalid appears after reset; last_grant is 1.
